// File: rtl/alu_issue.sv
// alu_issue: issue stage that registers one instruction onto the ALU bus and holds its result for writeback.
// Latency: result valid 2 cycles after the input handshake with a single-cycle ALU, +1 per cycle alu_done is low.
// Backpressure: one instruction in flight; in_ready only in IDLE, or in HOLD while out_ready is high.
// Optional: define ALU_ISSUE_TIMEOUT_EN to abort EXEC after TIMEOUT_CYCLES cycles without alu_done.

package opcode_pkg;
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_LSL  = 4'h4,
        OP_LSR  = 4'h5,
        OP_MUL  = 4'h6,
        OP_SP1  = 4'h7,
        OP_SP2  = 4'h8,
        OP_SP3  = 4'h9,
        OP_SP4  = 4'hA,
        OP_SP5  = 4'hB,
        OP_RES1 = 4'hC,
        OP_RES2 = 4'hD
    } opcode_t;
endpackage

module alu_issue #(
    parameter int DATA_W         = 32,
    parameter int RD_W           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wen,
    output logic              out_err,
    output logic              busy
);
    import opcode_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Result class is resolved at issue so EXEC only has to select, not decode.
    typedef enum logic [1:0] {
        CLS_WR  = 2'd0,
        CLS_NOP = 2'd1,
        CLS_ERR = 2'd2
    } cls_t;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("alu_issue: TIMEOUT_CYCLES must be >= 1");
    end

    function automatic cls_t decode_cls(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_LSL, OP_LSR, OP_MUL,
            OP_SP1, OP_SP2, OP_SP3, OP_SP4, OP_SP5: decode_cls = CLS_WR;
            OP_NOP:                                 decode_cls = CLS_NOP;
            default:                                decode_cls = CLS_ERR;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    cls_t                cls_q, cls_d;
    logic [RD_W-1:0]     out_rd_q, out_rd_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_wen_q, out_wen_d;
    logic                out_err_q, out_err_d;
    logic                take_in;

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen during the last EXEC cycle that is allowed to wait.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Next-state, handshake and capture decisions for the issue FSM.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        a_d        = a_q;
        b_d        = b_q;
        cls_d      = cls_q;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        out_wen_d  = out_wen_q;
        out_err_d  = out_err_q;
        in_ready   = 1'b0;
        take_in    = 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                take_in  = in_valid;
            end
            S_EXEC: begin
                if (alu_done) begin
                    // NOP and illegal ops still pass through EXEC; their ALU output is discarded.
                    out_rd_d   = rd_q;
                    out_data_d = (cls_q == CLS_WR) ? alu_result : '0;
                    out_wen_d  = (cls_q == CLS_WR);
                    out_err_d  = (cls_q == CLS_ERR);
                    state_d    = S_HOLD;
                end
`ifdef ALU_ISSUE_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    // Watchdog abort: report an error result instead of hanging the pipe.
                    out_rd_d   = rd_q;
                    out_data_d = '0;
                    out_wen_d  = 1'b0;
                    out_err_d  = 1'b1;
                    state_d    = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        take_in = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take_in) begin
            op_d    = in_op;
            rd_d    = in_rd;
            a_d     = in_a;
            b_d     = in_b;
            cls_d   = decode_cls(in_op);
            state_d = S_EXEC;
`ifdef ALU_ISSUE_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end
    end

    // State and datapath registers; synchronous active-low reset drops any in-flight instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NOP;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cls_q      <= CLS_NOP;
            out_rd_q   <= '0;
            out_data_q <= '0;
            out_wen_q  <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cls_q      <= cls_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
            out_wen_q  <= out_wen_d;
            out_err_q  <= out_err_d;
        end
    end

`ifdef ALU_ISSUE_TIMEOUT_EN
    // EXEC cycle counter for the watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign out_valid = (state_q == S_HOLD);
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign out_wen   = out_wen_q;
    assign out_err   = out_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vectors with literal expectations plus a queue-based result model
// checked every cycle. A behavioural ALU drives alu_result from the registered ALU bus.
// Timeout scenarios are compiled in when ALU_ISSUE_TIMEOUT_EN is defined.
module tb_alu_issue;
    import opcode_pkg::*;

    localparam int DW  = 32;
    localparam int RW  = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [RW-1:0] in_rd;
    logic [DW-1:0] in_a, in_b;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_a, alu_b;
    logic [DW-1:0] alu_result;
    logic          alu_done;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_rd;
    logic [DW-1:0] out_data;
    logic          out_wen;
    logic          out_err;
    logic          busy;

    alu_issue #(.DATA_W(DW), .RD_W(RW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_a(in_a), .in_b(in_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_done(alu_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_data(out_data), .out_wen(out_wen), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; ops without a defined result return a marker that must never reach writeback.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_LSL:  return a << b[4:0];
            OP_LSR:  return a >> b[4:0];
            OP_MUL:  return a * b;
            OP_SP1, OP_SP2, OP_SP3, OP_SP4, OP_SP5: return a ^ b ^ {28'd0, op};
            default: return 32'h0BAD_C0DE;
        endcase
    endfunction

    function automatic bit is_wr(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_LSL, OP_LSR, OP_MUL,
                          OP_SP1, OP_SP2, OP_SP3, OP_SP4, OP_SP5};
    endfunction

    assign alu_result = alu_model(alu_op, alu_a, alu_b);

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of accepted instructions with their expected results and EXEC progress.
    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        logic        wen;
        logic        err;
        bit          captured;
        int          cnt;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    bit          m_fire_out, m_fire_in;
    exp_t        m_e;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_op = OP_NOP;
            m_a  = '0;
            m_b  = '0;
        end else begin
            m_fire_out = (q.size() > 0) && q[0].captured && out_ready;
            m_fire_in  = in_valid && ((q.size() == 0) || m_fire_out);
            if ((q.size() > 0) && !q[0].captured) begin
                m_e = q[0];
                if (alu_done) begin
                    m_e.captured = 1'b1;
                end else begin
                    m_e.cnt++;
`ifdef ALU_ISSUE_TIMEOUT_EN
                    if (m_e.cnt == TMO) begin
                        m_e.captured = 1'b1;
                        m_e.data     = '0;
                        m_e.wen      = 1'b0;
                        m_e.err      = 1'b1;
                    end
`endif
                end
                q[0] = m_e;
            end else if (m_fire_out) begin
                void'(q.pop_front());
            end
            if (m_fire_in) begin
                m_e.rd       = in_rd;
                m_e.wen      = is_wr(in_op);
                m_e.err      = !m_e.wen && (in_op != OP_NOP);
                m_e.data     = m_e.wen ? alu_model(in_op, in_a, in_b) : 32'd0;
                m_e.captured = 1'b0;
                m_e.cnt      = 0;
                q.push_back(m_e);
                m_op = in_op;
                m_a  = in_a;
                m_b  = in_b;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'((q.size() > 0) && q[0].captured));
            chk("busy", 32'(busy), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready),
                32'((q.size() == 0) || ((q.size() > 0) && q[0].captured && out_ready)));
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            if ((q.size() > 0) && q[0].captured) begin
                chk("out_rd", 32'(out_rd), 32'(q[0].rd));
                chk("out_data", out_data, q[0].data);
                chk("out_wen", 32'(out_wen), 32'(q[0].wen));
                chk("out_err", 32'(out_err), 32'(q[0].err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [RW-1:0] rd, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_a     = a;
        in_b     = b;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        w;
        logic        e;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b1, 1'b0};
        tbl[1] = '{OP_LSL,  32'd1,         32'd4,         32'd16,        1'b1, 1'b0};
        tbl[2] = '{OP_LSR,  32'h8000_0000, 32'd31,        32'd1,         1'b1, 1'b0};
        tbl[3] = '{OP_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[4] = '{OP_SP3,  32'h0000_000F, 32'h0000_00F0, 32'h0000_00F6, 1'b1, 1'b0};
        tbl[5] = '{OP_RES2, 32'd1,         32'd2,         32'd0,         1'b0, 1'b1};
        tbl[6] = '{4'hF,    32'd1,         32'd2,         32'd0,         1'b0, 1'b1};
        tbl[7] = '{OP_NOP,  32'd1,         32'd2,         32'd0,         1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'h0;
        in_rd     = '0;
        in_a      = '0;
        in_b      = '0;
        alu_done  = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst alu_op", 32'(alu_op), 32'(OP_NOP));
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst out_data", out_data, 32'd0);

        // ADD 5+7 -> 12, valid two cycles after the handshake
        drive(OP_ADD, 4'd3, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        chk("add exec out_valid", 32'(out_valid), 32'd0);
        chk("add exec busy", 32'(busy), 32'd1);
        tick();
        chk("add out_valid", 32'(out_valid), 32'd1);
        chk("add out_data", out_data, 32'd12);
        chk("add out_rd", 32'(out_rd), 32'd3);
        chk("add out_wen", 32'(out_wen), 32'd1);
        chk("add out_err", 32'(out_err), 32'd0);
        tick();
        chk("add after busy", 32'(busy), 32'd0);
        chk("add after out_valid", 32'(out_valid), 32'd0);

        // MUL 6*7 with writeback stalled for three cycles
        drive(OP_MUL, 4'd6, 32'd6, 32'd7);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("mul hold out_data", out_data, 32'd42);
            chk("mul hold in_ready", 32'(in_ready), 32'd0);
            chk("mul hold out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        chk("mul final out_data", out_data, 32'd42);
        tick();
        chk("mul done out_valid", 32'(out_valid), 32'd0);

        // Back-to-back ADD then SUB with in_valid continuous
        drive(OP_ADD, 4'd1, 32'd1, 32'd2);
        tick();
        drive(OP_SUB, 4'd2, 32'd10, 32'd3);
        chk("b2b exec in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("b2b first data", out_data, 32'd3);
        chk("b2b first rd", 32'(out_rd), 32'd1);
        chk("b2b hold in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b gap out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("b2b second data", out_data, 32'd7);
        chk("b2b second rd", 32'(out_rd), 32'd2);
        tick();

        // RES1 then NOP
        drive(OP_RES1, 4'd5, 32'd9, 32'd9);
        tick();
        in_valid = 1'b0;
        tick();
        chk("res1 out_data", out_data, 32'd0);
        chk("res1 out_wen", 32'(out_wen), 32'd0);
        chk("res1 out_err", 32'(out_err), 32'd1);
        tick();
        drive(OP_NOP, 4'd5, 32'd9, 32'd9);
        tick();
        in_valid = 1'b0;
        tick();
        chk("nop out_wen", 32'(out_wen), 32'd0);
        chk("nop out_err", 32'(out_err), 32'd0);
        chk("nop out_data", out_data, 32'd0);
        tick();

        // Opcode class table
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].op, 4'(i), tbl[i].a, tbl[i].b);
            tick();
            in_valid = 1'b0;
            tick();
            chk("tbl out_data", out_data, tbl[i].d);
            chk("tbl out_wen", 32'(out_wen), 32'(tbl[i].w));
            chk("tbl out_err", 32'(out_err), 32'(tbl[i].e));
            tick();
        end

        // Multi-cycle ALU: three extra cycles with alu_done low
        alu_done = 1'b0;
        drive(OP_ADD, 4'd5, 32'd100, 32'd23);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mc wait out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        alu_done = 1'b1;
        chk("mc last exec out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("mc out_valid", 32'(out_valid), 32'd1);
        chk("mc out_data", out_data, 32'd123);
        tick();

`ifdef ALU_ISSUE_TIMEOUT_EN
        // Watchdog abort after 16 EXEC cycles
        alu_done = 1'b0;
        drive(OP_ADD, 4'd9, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("tmo wait out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        chk("tmo cycle16 out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("tmo out_valid", 32'(out_valid), 32'd1);
        chk("tmo out_err", 32'(out_err), 32'd1);
        chk("tmo out_data", out_data, 32'd0);
        chk("tmo out_wen", 32'(out_wen), 32'd0);
        chk("tmo out_rd", 32'(out_rd), 32'd9);
        tick();
        // alu_done on the final counted cycle wins
        drive(OP_ADD, 4'd8, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        alu_done = 1'b1;
        tick();
        chk("late out_valid", 32'(out_valid), 32'd1);
        chk("late out_err", 32'(out_err), 32'd0);
        chk("late out_data", out_data, 32'd12);
        tick();
`else
        // Without the watchdog EXEC waits indefinitely
        alu_done = 1'b0;
        drive(OP_ADD, 4'd4, 32'd1, 32'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("nowd wait out_valid", 32'(out_valid), 32'd0);
            chk("nowd wait busy", 32'(busy), 32'd1);
            tick();
        end
        alu_done = 1'b1;
        tick();
        chk("nowd out_valid", 32'(out_valid), 32'd1);
        chk("nowd out_data", out_data, 32'd2);
        tick();
`endif

        // Reset in EXEC drops the instruction
        alu_done = 1'b0;
        drive(OP_ADD, 4'd3, 32'd3, 32'd4);
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2 out_valid", 32'(out_valid), 32'd0);
        chk("rst2 in_ready", 32'(in_ready), 32'd1);
        chk("rst2 alu_op", 32'(alu_op), 32'(OP_NOP));
        chk("rst2 busy", 32'(busy), 32'd0);
        chk("rst2 alu_a", alu_a, 32'd0);
        alu_done = 1'b1;
        tick();
        chk("rst2 idle out_valid", 32'(out_valid), 32'd0);
        drive(OP_ADD, 4'd7, 32'd2, 32'd2);
        tick();
        in_valid = 1'b0;
        tick();
        chk("post rst out_valid", 32'(out_valid), 32'd1);
        chk("post rst out_data", out_data, 32'd4);
        chk("post rst out_rd", 32'(out_rd), 32'd7);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
